// File: rtl/mips_cpu_mem_pkg.sv
// Shared types and helpers for the MIPS CPU load/store unit.
// Op encoding, FSM states, access size and alignment helpers.
package mips_cpu_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd7,
    OP_SH  = 4'd8,
    OP_SW  = 4'd9
  } mem_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RDATA,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_WL,
    SZ_WR
  } size_t;

  function automatic logic is_load(mem_op_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU,
                      OP_LW, OP_LWL, OP_LWR};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic size_t op_size(mem_op_t op);
    size_t s;
    unique case (op)
      OP_LB, OP_LBU, OP_SB: s = SZ_B;
      OP_LH, OP_LHU, OP_SH: s = SZ_H;
      OP_LWL:               s = SZ_WL;
      OP_LWR:               s = SZ_WR;
      default:              s = SZ_W;
    endcase
    return s;
  endfunction

  // LWL/LWR are unaligned by design, so they never fault.
  function automatic logic misaligned(mem_op_t op, logic [1:0] k);
    logic m;
    unique case (op_size(op))
      SZ_H:    m = k[0];
      SZ_W:    m = (k != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Load result formatter: lane select, extension and LWL/LWR merge.
// Purely combinational; fed from the latched request and bus data.
module mips_cpu_load_align
  import mips_cpu_mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  k,
  input  logic [31:0] d,
  input  logic [31:0] rt_old,
  output logic [31:0] rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [1:0]  w_kn;
  logic [31:0] w_lmask;
  logic [31:0] w_rmask;

  // Extract the addressed lane and build the merge masks.
  always_comb begin
    w_byte  = d[{k, 3'b000} +: 8];
    w_half  = k[1] ? d[31:16] : d[15:0];
    w_kn    = 2'd3 - k;
    w_lmask = ~(32'hFFFF_FFFF << {w_kn, 3'b000});
    w_rmask = ~(32'hFFFF_FFFF >> {k, 3'b000});
  end

  // Select the formatted result for the op.
  always_comb begin
    rdata = d;
    unique case (op)
      OP_LB:  rdata = {{24{w_byte[7]}}, w_byte};
      OP_LBU: rdata = {24'h0, w_byte};
      OP_LH:  rdata = {{16{w_half[15]}}, w_half};
      OP_LHU: rdata = {16'h0, w_half};
      OP_LWL: rdata = (d << {w_kn, 3'b000})
                    | (rt_old & w_lmask);
      OP_LWR: rdata = (d >> {k, 3'b000})
                    | (rt_old & w_rmask);
      default: rdata = d;
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_ctrl.sv
// CPU-side load/store unit driving an Avalon-style data port.
// One word-aligned bus access per request, one-cycle response.
module mips_cpu_mem_ctrl
  import mips_cpu_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  mem_op_t           req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_rt_old,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest
);

  state_t            r_state;
  state_t            w_state_nxt;
  mem_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rt_old;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [1:0]        w_k;
  logic              w_accept;
  logic              w_mis;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load;

  assign w_k         = r_addr[1:0];
  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_mis       = misaligned(req_op, req_addr[1:0]);
  assign mem_address = {r_addr[ADDR_W-1:2], 2'b00};
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;

  mips_cpu_load_align u_align (
    .op     (r_op),
    .k      (w_k),
    .d      (mem_readdata),
    .rt_old (r_rt_old),
    .rdata  (w_load)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and bus/handshake strobes.
  always_comb begin
    w_state_nxt    = r_state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = 4'b0000;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          w_state_nxt = w_mis ? S_DONE : S_BUS;
      end
      S_BUS: begin
        mem_read       = is_load(r_op);
        mem_write      = is_store(r_op);
        mem_byteenable = w_be;
        if (!mem_waitrequest)
          w_state_nxt = is_load(r_op) ? S_RDATA : S_DONE;
      end
      S_RDATA: w_state_nxt = S_DONE;
      S_DONE: begin
        resp_valid  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane enables and replicated store data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    unique case (op_size(r_op))
      SZ_B: begin
        w_be    = 4'b0001 << w_k;
        w_wdata = {4{r_wdata[7:0]}};
      end
      SZ_H: begin
        w_be    = 4'b0011 << w_k;
        w_wdata = {2{r_wdata[15:0]}};
      end
      SZ_WL: w_be = 4'b1111 >> (2'd3 - w_k);
      SZ_WR: w_be = 4'b1111 << w_k;
      default: w_be = 4'b1111;
    endcase
  end

  assign mem_writedata = w_wdata;

  // Request latch, load result and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= OP_LB;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rt_old <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= req_op;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_rt_old <= req_rt_old;
        r_err    <= w_mis;
      end
      if (r_state == S_RDATA) r_rdata <= w_load;
      if (r_state == S_DONE)  r_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_ctrl.sv
// Directed bench for mips_cpu_mem_ctrl.
// Hand-computed vectors; all checks go through chk.
module tb_mips_cpu_mem_ctrl;
  import mips_cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  mem_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_cpu_mem_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_rt_old      (req_rt_old),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic run(input string nm, input mem_op_t op,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rt, input logic [31:0] d,
                     input int nw, input logic [31:0] ead,
                     input logic [3:0] ebe, input logic [31:0] ewd,
                     input logic [31:0] erd, input logic eerr,
                     input int elat);
    int cyc;
    int bus;
    int lat;
    logic got;
    logic both;
    logic unst;
    logic saw_rd;
    logic saw_wr;
    logic err;
    logic [31:0] rd;
    logic [31:0] ad0;
    logic [31:0] wd0;
    logic [3:0]  be0;
    bus = 0; lat = 0; got = 0; both = 0; unst = 0;
    saw_rd = 0; saw_wr = 0; err = 0; rd = '0;
    ad0 = '0; wd0 = '0; be0 = '0;
    @(negedge clk);
    chk({nm, ".ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a;
    req_wdata = wd; req_rt_old = rt;
    mem_readdata = d; mem_waitrequest = 1'b0;
    cyc = 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!got && cyc < 30) begin
      cyc++;
      if (mem_read && mem_write) both = 1'b1;
      if (mem_read)  saw_rd = 1'b1;
      if (mem_write) saw_wr = 1'b1;
      if (mem_read || mem_write) begin
        bus++;
        if (bus == 1) begin
          ad0 = mem_address; be0 = mem_byteenable;
          wd0 = mem_writedata;
        end else if (mem_address !== ad0 ||
                     mem_byteenable !== be0 ||
                     mem_writedata !== wd0) begin
          unst = 1'b1;
        end
        mem_waitrequest = (bus <= nw);
      end else begin
        mem_waitrequest = 1'b0;
      end
      if (resp_valid) begin
        got = 1'b1; lat = cyc;
        rd = resp_rdata; err = resp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    mem_waitrequest = 1'b0;
    chk({nm, ".resp"}, {31'h0, got}, 32'd1);
    chk({nm, ".lat"}, lat, elat);
    chk({nm, ".err"}, {31'h0, err}, {31'h0, eerr});
    chk({nm, ".both"}, {31'h0, both}, 32'd0);
    chk({nm, ".rd"}, {31'h0, saw_rd},
        {31'h0, is_load(op) && !eerr});
    chk({nm, ".wr"}, {31'h0, saw_wr},
        {31'h0, is_store(op) && !eerr});
    if (!eerr) begin
      chk({nm, ".addr"}, ad0, ead);
      chk({nm, ".be"}, {28'h0, be0}, {28'h0, ebe});
      chk({nm, ".stable"}, {31'h0, unst}, 32'd0);
      if (is_store(op)) chk({nm, ".wd"}, wd0, ewd);
      if (is_load(op))  chk({nm, ".rdata"}, rd, erd);
    end
    @(posedge clk); #1;
    chk({nm, ".pulse"}, {31'h0, resp_valid}, 32'd0);
    chk({nm, ".errclr"}, {31'h0, resp_err}, 32'd0);
  endtask

  initial begin
    logic bad_rv;
    rst_n = 1'b0; req_valid = 1'b0; req_op = OP_LW;
    req_addr = '0; req_wdata = '0; req_rt_old = '0;
    mem_readdata = '0; mem_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", {31'h0, req_ready}, 32'd1);
    chk("rst.rd", {31'h0, mem_read}, 32'd0);
    chk("rst.wr", {31'h0, mem_write}, 32'd0);
    chk("rst.be", {28'h0, mem_byteenable}, 32'd0);
    chk("rst.rv", {31'h0, resp_valid}, 32'd0);
    chk("rst.err", {31'h0, resp_err}, 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;

    run("sw", OP_SW, 32'h100, 32'hDEADBEEF, 0, 0, 0,
        32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 3);
    run("sb", OP_SB, 32'h103, 32'h000000A5, 0, 0, 0,
        32'h100, 4'b1000, 32'hA5A5A5A5, 0, 0, 3);
    run("lb", OP_LB, 32'h102, 0, 0, 32'h12F45678, 0,
        32'h100, 4'b0100, 0, 32'hFFFFFFF4, 0, 4);
    run("lbu", OP_LBU, 32'h102, 0, 0, 32'h12F45678, 0,
        32'h100, 4'b0100, 0, 32'h000000F4, 0, 4);
    run("lh_mis", OP_LH, 32'h101, 0, 0, 32'h12F45678, 0,
        0, 0, 0, 0, 1, 2);
    run("lwl", OP_LWL, 32'h101, 0, 32'h11223344,
        32'hAABBCCDD, 0,
        32'h100, 4'b0011, 0, 32'hCCDD3344, 0, 4);
    run("lwr", OP_LWR, 32'h102, 0, 32'h11223344,
        32'hAABBCCDD, 0,
        32'h100, 4'b1100, 0, 32'h1122AABB, 0, 4);
    run("lw_ws", OP_LW, 32'h200, 0, 0, 32'hCAFEF00D, 3,
        32'h200, 4'b1111, 0, 32'hCAFEF00D, 0, 7);
    run("sh", OP_SH, 32'h102, 32'h1234BEEF, 0, 0, 1,
        32'h100, 4'b1100, 32'hBEEFBEEF, 0, 0, 4);
    run("lhu", OP_LHU, 32'h102, 0, 0, 32'h80017FFF, 0,
        32'h100, 4'b1100, 0, 32'h00008001, 0, 4);
    run("lh", OP_LH, 32'h100, 0, 0, 32'h80017FFF, 0,
        32'h100, 4'b0011, 0, 32'h00007FFF, 0, 4);
    run("sw_mis", OP_SW, 32'h102, 32'h1, 0, 0, 0,
        0, 0, 0, 0, 1, 2);
    run("lwl3", OP_LWL, 32'h203, 0, 32'h11223344,
        32'hAABBCCDD, 0,
        32'h200, 4'b1111, 0, 32'hAABBCCDD, 0, 4);

    // Reset while the bus is stalled.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h300;
    mem_waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mrst.busrd", {31'h0, mem_read}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_waitrequest = 1'b0;
    chk("mrst.rd", {31'h0, mem_read}, 32'd0);
    chk("mrst.be", {28'h0, mem_byteenable}, 32'd0);
    chk("mrst.ready", {31'h0, req_ready}, 32'd1);
    bad_rv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid || mem_read) bad_rv = 1'b1;
      @(posedge clk); #1;
    end
    chk("mrst.norv", {31'h0, bad_rv}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
